// File: rtl/axis_parse_ctrl.sv
// axis_parse_ctrl: sequences the field parsers over one AXI-Stream packet.
// It reports the parsed field set to a consumer and holds off upstream while
// a verdict is pending. It also counts reported packets and packets that end
// before every required field is ready.
module axis_parse_ctrl #(
  parameter int unsigned NUM_FIELDS      = 4,
  parameter int unsigned SHORT_CNT_WIDTH = 16
) (
  input  logic                       axis_aclk,
  input  logic                       axis_resetn,
  input  logic                       axis_tvalid,
  input  logic                       axis_tready,
  input  logic                       axis_tlast,
  input  logic [NUM_FIELDS-1:0]      field_ready,
  input  logic [NUM_FIELDS-1:0]      field_mask,
  input  logic                       fields_ack,
  output logic                       parser_reset,
  output logic                       fields_valid,
  output logic                       stream_hold,
  output logic [31:0]                pkt_count,
  output logic [SHORT_CNT_WIDTH-1:0] short_count
);

  localparam int unsigned PKT_W   = 32;
  localparam int unsigned SHORT_W = SHORT_CNT_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PARSE  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_REPORT = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic               r_tlast_seen;
  logic               w_tlast_seen_nxt;
  logic               w_beat;
  logic               w_last_beat;
  logic               w_all_ready;
  logic               w_pkt_inc;
  logic               w_short_inc;
  logic               w_hold_nxt;
  logic               r_parser_reset;
  logic               r_fields_valid;
  logic               r_stream_hold;
  logic [PKT_W-1:0]   r_pkt_count;
  logic [SHORT_W-1:0] r_short_count;

  // A field counts as ready if it is not required by the mask.
  assign w_all_ready = &(field_ready | ~field_mask);
  assign w_beat      = axis_tvalid && axis_tready;
  assign w_last_beat = w_beat && axis_tlast;

  // Next-state, tlast tracking and counter-increment decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_tlast_seen_nxt = r_tlast_seen;
    w_pkt_inc        = 1'b0;
    w_short_inc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_last_beat) begin
          w_state_nxt      = S_CHECK;
          w_tlast_seen_nxt = 1'b1;
        end else if (w_beat) begin
          w_state_nxt = S_PARSE;
        end
      end
      S_PARSE: begin
        // Ready wins over a coincident tlast; the tlast is still remembered.
        if (w_all_ready) begin
          w_state_nxt      = S_REPORT;
          w_tlast_seen_nxt = w_last_beat;
        end else if (w_last_beat) begin
          w_state_nxt      = S_CHECK;
          w_tlast_seen_nxt = 1'b1;
        end
      end
      S_CHECK: begin
        // One cycle to let the parsers' registered ready settle after tlast.
        if (w_all_ready) begin
          w_state_nxt = S_REPORT;
        end else begin
          w_state_nxt = S_CLEAR;
          w_short_inc = 1'b1;
        end
      end
      S_REPORT: begin
        if (w_last_beat) begin
          w_tlast_seen_nxt = 1'b1;
        end
        if (fields_ack) begin
          w_pkt_inc = 1'b1;
          if (r_tlast_seen || w_last_beat) begin
            w_state_nxt = S_CLEAR;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_last_beat) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state_nxt      = S_IDLE;
        w_tlast_seen_nxt = 1'b0;
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_tlast_seen_nxt = 1'b0;
      end
    endcase
  end

  // Hold upstream while a verdict is pending or the packet has fully arrived.
  assign w_hold_nxt = (w_state_nxt == S_CHECK) || (w_state_nxt == S_CLEAR) ||
                      ((w_state_nxt == S_REPORT) && w_tlast_seen_nxt);

  // State, tlast flag and outputs; outputs are state decodes registered alongside the state.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state        <= S_IDLE;
      r_tlast_seen   <= 1'b0;
      r_parser_reset <= 1'b0;
      r_fields_valid <= 1'b0;
      r_stream_hold  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_tlast_seen   <= w_tlast_seen_nxt;
      r_parser_reset <= (w_state_nxt == S_CLEAR);
      r_fields_valid <= (w_state_nxt == S_REPORT);
      r_stream_hold  <= w_hold_nxt;
    end
  end

  // Packet counter, wraps naturally.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_pkt_count <= '0;
    end else if (w_pkt_inc) begin
      r_pkt_count <= r_pkt_count + PKT_W'(1);
    end
  end

  // Short-packet counter, saturates at all-ones.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_short_count <= '0;
    end else if (w_short_inc && (r_short_count != {SHORT_W{1'b1}})) begin
      r_short_count <= r_short_count + SHORT_W'(1);
    end
  end

  assign parser_reset = r_parser_reset;
  assign fields_valid = r_fields_valid;
  assign stream_hold  = r_stream_hold;
  assign pkt_count    = r_pkt_count;
  assign short_count  = r_short_count;

endmodule

// File: tb/tb_axis_parse_ctrl.sv
// Directed bench for axis_parse_ctrl. Each packet pushes its expected end-of-packet
// record; a monitor pops it on every parser_reset pulse. Cycle-level expectations are
// checked inline. The short counter is narrowed to 8 bits so saturation is reachable quickly.
module tb_axis_parse_ctrl;

  localparam int unsigned NF  = 4;
  localparam int unsigned SCW = 8;

  logic           clk;
  logic           rstn;
  logic           tvalid;
  logic           tready;
  logic           tlast;
  logic [NF-1:0]  fready;
  logic [NF-1:0]  fmask;
  logic           ack;
  logic           parser_reset;
  logic           fields_valid;
  logic           stream_hold;
  logic [31:0]    pkt_count;
  logic [SCW-1:0] short_count;

  typedef struct {
    bit          fv;
    int unsigned pkt;
    int unsigned sht;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int unsigned m_pkt = 0;
  int unsigned m_sht = 0;

  axis_parse_ctrl #(.NUM_FIELDS(NF), .SHORT_CNT_WIDTH(SCW)) dut (
    .axis_aclk   (clk),
    .axis_resetn (rstn),
    .axis_tvalid (tvalid),
    .axis_tready (tready),
    .axis_tlast  (tlast),
    .field_ready (fready),
    .field_mask  (fmask),
    .fields_ack  (ack),
    .parser_reset(parser_reset),
    .fields_valid(fields_valid),
    .stream_hold (stream_hold),
    .pkt_count   (pkt_count),
    .short_count (short_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit l);
    tvalid = v;
    tlast  = l;
  endtask

  task automatic push(input bit fv);
    exp_t e;
    e.fv  = fv;
    e.pkt = m_pkt;
    e.sht = m_sht;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: one record per packet, popped when the parsers are cleared.
  initial begin
    bit   fv_seen;
    exp_t e;
    fv_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        fv_seen = 1'b0;
      end else begin
        if (fields_valid) fv_seen = 1'b1;
        if (parser_reset) begin
          if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_unexpected: parser_reset with no expected packet at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("sb_fields_valid_seen", longint'(fv_seen), longint'(e.fv));
            chk("sb_pkt_count", longint'(pkt_count), longint'(e.pkt));
            chk("sb_short_count", longint'(short_count), longint'(e.sht));
          end
          fv_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; tvalid = 1'b0; tready = 1'b1; tlast = 1'b0;
    fready = '0; fmask = '0; ack = 1'b0;
    #12;
    chk("rst_parser_reset", parser_reset, 0);
    chk("rst_fields_valid", fields_valid, 0);
    chk("rst_stream_hold", stream_hold, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_short_count", short_count, 0);
    step();
    rstn = 1'b1;

    // 3-beat packet, ready after beat 1, ack two cycles later, then drain to tlast.
    fmask = 4'b0011;
    m_pkt = 1; push(1'b1);
    drive(1, 0); step();                        // IDLE -> PARSE
    chk("p1_parse_fv", fields_valid, 0);
    drive(0, 0); fready = 4'b0011; step();      // PARSE -> REPORT
    chk("p1_report_fv", fields_valid, 1);
    chk("p1_report_hold", stream_hold, 0);
    drive(1, 0); step();                        // beat 2 while REPORT
    chk("p1_report_stable", fields_valid, 1);
    drive(0, 0); ack = 1'b1; step();            // ack -> DRAIN
    chk("p1_drain_fv", fields_valid, 0);
    chk("p1_drain_pkt", pkt_count, 1);
    chk("p1_drain_hold", stream_hold, 0);
    ack = 1'b0; drive(1, 1); step();            // tlast -> CLEAR
    chk("p1_clear_pr", parser_reset, 1);
    chk("p1_clear_hold", stream_hold, 1);
    drive(0, 0); fready = '0; step();           // -> IDLE
    chk("p1_idle_pr", parser_reset, 0);
    chk("p1_idle_hold", stream_hold, 0);

    // Single-beat packet, ready one cycle after tlast.
    m_pkt = 2; push(1'b1);
    drive(1, 1); step();                        // IDLE -> CHECK
    chk("p2_check_hold", stream_hold, 1);
    chk("p2_check_fv", fields_valid, 0);
    drive(0, 0); fready = 4'b0011; step();      // CHECK -> REPORT
    chk("p2_report_fv", fields_valid, 1);
    chk("p2_report_hold", stream_hold, 1);
    ack = 1'b1; step();                         // -> CLEAR
    chk("p2_clear_pr", parser_reset, 1);
    chk("p2_clear_hold", stream_hold, 1);
    chk("p2_clear_short", short_count, 0);
    ack = 1'b0; fready = '0; step();
    chk("p2_idle_hold", stream_hold, 0);

    // Short packet: field 2 never ready.
    fmask = 4'b0111; fready = 4'b0011;
    m_sht = 1; push(1'b0);
    drive(1, 0); step();                        // -> PARSE
    drive(1, 1); step();                        // -> CHECK
    chk("p3_check_hold", stream_hold, 1);
    drive(0, 0); step();                        // -> CLEAR
    chk("p3_clear_pr", parser_reset, 1);
    chk("p3_short", short_count, 1);
    chk("p3_pkt", pkt_count, 2);
    fready = '0; step();

    // Ack withheld 10 cycles after tlast.
    fmask = 4'b0001;
    m_pkt = 3; push(1'b1);
    drive(1, 1); step();                        // -> CHECK
    drive(0, 0); fready = 4'b0001; step();      // -> REPORT
    for (int i = 0; i < 10; i++) begin
      chk("p4_wait_hold", stream_hold, 1);
      chk("p4_wait_fv", fields_valid, 1);
      step();
    end
    ack = 1'b1; step();                         // -> CLEAR
    chk("p4_clear_pr", parser_reset, 1);
    chk("p4_pkt", pkt_count, 3);
    ack = 1'b0; fready = '0; step();

    // Ready and tlast in the same PARSE cycle go to REPORT with tlast remembered.
    m_pkt = 4; push(1'b1);
    drive(1, 0); step();                        // -> PARSE
    drive(1, 1); fready = 4'b0001; step();      // -> REPORT (tlast_seen)
    chk("p5_report_fv", fields_valid, 1);
    chk("p5_report_hold", stream_hold, 1);
    drive(0, 0); ack = 1'b1; step();            // -> CLEAR
    chk("p5_clear_pr", parser_reset, 1);
    ack = 1'b0; fready = '0; step();

    // tlast beat in the ack cycle goes straight to CLEAR.
    m_pkt = 5; push(1'b1);
    drive(1, 0); step();                        // -> PARSE
    drive(0, 0); fready = 4'b0001; step();      // -> REPORT, no tlast yet
    chk("p6_report_hold", stream_hold, 0);
    drive(1, 1); ack = 1'b1; step();            // -> CLEAR
    chk("p6_clear_pr", parser_reset, 1);
    drive(0, 0); ack = 1'b0; fready = '0; step();

    // Zero mask: all_ready regardless of field_ready.
    fmask = '0;
    m_pkt = 6; push(1'b1);
    drive(1, 0); step();                        // -> PARSE
    drive(0, 0); step();                        // -> REPORT
    chk("p7_zero_mask_fv", fields_valid, 1);
    ack = 1'b1; step();                         // -> DRAIN
    chk("p7_drain_fv", fields_valid, 0);
    ack = 1'b0; drive(1, 1); step();            // -> CLEAR
    drive(0, 0); step();

    // Asynchronous reset during REPORT, then a normal packet.
    fmask = 4'b0001;
    drive(1, 1); step();                        // -> CHECK
    drive(0, 0); fready = 4'b0001; step();      // -> REPORT
    chk("p8_report_fv", fields_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("p8_async_fv", fields_valid, 0);
    chk("p8_async_hold", stream_hold, 0);
    chk("p8_async_pr", parser_reset, 0);
    chk("p8_async_pkt", pkt_count, 0);
    chk("p8_async_short", short_count, 0);
    fready = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    m_pkt = 1; m_sht = 0; push(1'b1);
    drive(1, 1); step();                        // first edge after release -> CHECK
    chk("p9_check_hold", stream_hold, 1);
    drive(0, 0); fready = 4'b0001; step();      // -> REPORT
    chk("p9_report_fv", fields_valid, 1);
    ack = 1'b1; step();                         // -> CLEAR
    chk("p9_pkt", pkt_count, 1);
    ack = 1'b0; fready = '0; step();

    // Short counter saturation: 2^SCW short packets, counter must stick at all-ones.
    for (int k = 0; k < (1 << SCW); k++) begin
      if (m_sht < (1 << SCW) - 1) m_sht++;
      push(1'b0);
      drive(1, 1); step();                      // -> CHECK
      drive(0, 0); step();                      // -> CLEAR
      step();                                   // -> IDLE
      if (k == (1 << SCW) - 2) chk("sat_reach_max", short_count, (1 << SCW) - 1);
    end
    chk("sat_hold_max", short_count, (1 << SCW) - 1);
    chk("sat_pkt_unchanged", pkt_count, 1);

    step(); step();
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_parse_ctrl.md
AXIS_PARSE_CTRL -- requirements
Module: axis_parse_ctrl

Interface
REQ-001 Parameter: NUM_FIELDS, default 4, number of field parsers sequenced.
REQ-002 Parameter: SHORT_CNT_WIDTH, default 16, width of the short-packet counter.
REQ-003 Port: axis_aclk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: axis_resetn  input  1  asynchronous, active-low reset.
REQ-005 Port: axis_tvalid, axis_tready, axis_tlast  input  1 each  probed stream handshake; a beat is tvalid && tready.
REQ-006 Port: field_ready  input  NUM_FIELDS  parsed_value_ready from each field parser.
REQ-007 Port: field_mask  input  NUM_FIELDS  required-field enables; quasi-static, changed only while state is IDLE.
REQ-008 Port: fields_ack  input  1  downstream consumer accepts the parsed field set.
REQ-009 Port: parser_reset  output  1  explicit reset to all field parsers.
REQ-010 Port: fields_valid  output  1  parsed field set is complete and stable.
REQ-011 Port: stream_hold  output  1  upstream SHALL gate axis_tready low while this is high.
REQ-012 Port: pkt_count  output  32  packets reported, wraps modulo 2^32.
REQ-013 Port: short_count  output  SHORT_CNT_WIDTH  packets ending before all required fields, saturating.

Function
REQ-014 all_ready SHALL be &(field_ready | ~field_mask); a zero mask gives all_ready = 1.
REQ-015 FSM states: IDLE, PARSE, CHECK, REPORT, DRAIN, CLEAR; register tlast_seen.
REQ-016 IDLE: beat with tlast -> CHECK with tlast_seen=1; beat without tlast -> PARSE; no beat -> stay.
REQ-017 PARSE: all_ready -> REPORT, with tlast_seen set to the current beat's tlast; else tlast beat -> CHECK with tlast_seen=1; else stay.
REQ-018 CHECK lasts exactly one cycle, covering the one-cycle parser ready latency: all_ready -> REPORT; else -> CLEAR with short_count increment.
REQ-019 REPORT: a tlast beat sets tlast_seen; fields_ack with tlast_seen (or a tlast beat in the same cycle) -> CLEAR; fields_ack without it -> DRAIN; pkt_count increments on the ack cycle.
REQ-020 DRAIN: tlast beat -> CLEAR; other beats are ignored.
REQ-021 CLEAR lasts exactly one cycle, then -> IDLE; tlast_seen clears on entry to IDLE.
REQ-022 Outputs SHALL be Moore, decoded from registered state only, with no combinational input-to-output path.
REQ-023 Output decodes: parser_reset = (state==CLEAR); fields_valid = (state==REPORT); stream_hold = CHECK || CLEAR || (REPORT && tlast_seen).
REQ-024 fields_valid SHALL stay high from REPORT entry until the ack cycle inclusive; it is never withdrawn without an ack.
REQ-025 Simultaneous all_ready and tlast beat in PARSE SHALL go to REPORT (not CHECK), with tlast_seen=1.
REQ-026 short_count SHALL saturate at all-ones; pkt_count SHALL wrap.
REQ-027 A beat while stream_hold is high is an upstream protocol violation; it SHALL be ignored except in REPORT, where tlast still sets tlast_seen.

Reset
REQ-028 While axis_resetn is low: state=IDLE, tlast_seen=0, parser_reset=0, fields_valid=0, stream_hold=0, pkt_count=0, short_count=0.
REQ-029 Reset mid-packet SHALL abandon the packet with no counter update; the parsers are cleared by their own axis_resetn.
REQ-030 Reset deassertion needs no synchronisation inside this block; the first beat is accepted on the first edge after deassertion.

Verification
REQ-031 Stimulus: mask=4'b0011; 3-beat packet; fields 0/1 ready after beat 1; ack 2 cycles later; tlast on beat 3. Response: fields_valid high 1 cycle after ready; DRAIN after ack; parser_reset pulse one cycle after tlast; pkt_count=1.
REQ-032 Stimulus: single-beat packet with tlast; field_ready rises the next cycle. Response: IDLE->CHECK->REPORT; stream_hold high from CHECK until CLEAR exits; short_count=0.
REQ-033 Stimulus: 2-beat packet; field 2 of mask 4'b0111 never readies. Response: CHECK->CLEAR; fields_valid never asserted; short_count=1; pkt_count unchanged.
REQ-034 Stimulus: short_count preloaded to 0xFFFF via 65535 short packets, then one more short packet. Response: short_count stays 0xFFFF.
REQ-035 Stimulus: ack withheld 10 cycles after tlast. Response: stream_hold high all 10 cycles; fields_valid stable; CLEAR on the ack cycle +1.
REQ-036 Stimulus: axis_resetn asserted during REPORT. Response: all outputs 0 immediately (asynchronously); the next packet is parsed normally.
